key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_event.sv | 179 +++++++++++++++++
 tb/tb_key_event.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// -----------------------------------------------------------------------------
// key_event
// Classifies a debounced, active-low key into short press, double-click,
// long press and auto-repeat events. All event outputs are one-cycle,
// registered pulses; at most one of them is high in any cycle.
//
// Parameters
//   LONG_TIME   : hold cycles before a press becomes a long press (<= 2^26)
//   DOUBLE_TIME : cycles after a release in which a second press is a
//                 double-click (<= 2^26)
//   REPEAT_TIME : auto-repeat period while a long press is held (<= 2^26)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   key_in       in   debounced key level, 0 = pressed, idle high
//   short_pulse  out  single short press completed
//   double_pulse out  double-click completed
//   long_pulse   out  key held LONG_TIME cycles
//   repeat_pulse out  every REPEAT_TIME cycles while a long press is held
//   key_held     out  high while the key is considered pressed
// -----------------------------------------------------------------------------
module key_event #(
    parameter int LONG_TIME   = 25_000_000,
    parameter int DOUBLE_TIME = 12_500_000,
    parameter int REPEAT_TIME = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic key_held
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_LONG   = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_PRESS2 = 3'd4
    } state_t;

    // Terminal counts; the shared counter runs from 0 up to value-1.
    localparam logic [25:0] LONG_TC   = 26'(LONG_TIME - 1);
    localparam logic [25:0] DOUBLE_TC = 26'(DOUBLE_TIME - 1);
    localparam logic [25:0] REPEAT_TC = 26'(REPEAT_TIME - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [25:0] r_cnt;
    logic [25:0] w_cnt_nxt;
    logic        r_key_d;
    logic        r_armed;
    logic        r_short;
    logic        r_double;
    logic        r_long;
    logic        r_repeat;
    logic        r_key_held;
    logic        w_short_nxt;
    logic        w_double_nxt;
    logic        w_long_nxt;
    logic        w_repeat_nxt;
    logic        w_held_nxt;
    logic        w_press;
    logic        w_release;

    // A falling edge only counts once the key has been seen released since
    // reset, so a key already held down through reset is not a press.
    assign w_press   = r_key_d & ~key_in & r_armed;
    assign w_release = key_in;

    // Next-state, counter and pulse decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_short_nxt  = 1'b0;
        w_double_nxt = 1'b0;
        w_long_nxt   = 1'b0;
        w_repeat_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 26'd0;
                if (w_press) begin
                    w_state_nxt = ST_PRESS1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                // Release wins over the long-press terminal count.
                if (w_release) begin
                    w_state_nxt = ST_WAIT2;
                    w_cnt_nxt   = 26'd0;
                end else if (r_cnt == LONG_TC) begin
                    w_state_nxt = ST_LONG;
                    w_long_nxt  = 1'b1;
                    w_cnt_nxt   = 26'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 26'd1;
                end
            end
            ST_LONG: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 26'd0;
                end else if (r_cnt == REPEAT_TC) begin
                    w_repeat_nxt = 1'b1;
                    w_cnt_nxt    = 26'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 26'd1;
                end
            end
            ST_WAIT2: begin
                // A second press wins over the double-click window expiry.
                if (w_press) begin
                    w_state_nxt = ST_PRESS2;
                    w_cnt_nxt   = 26'd0;
                end else if (r_cnt == DOUBLE_TC) begin
                    w_state_nxt = ST_IDLE;
                    w_short_nxt = 1'b1;
                    w_cnt_nxt   = 26'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 26'd1;
                end
            end
            ST_PRESS2: begin
                // No long/repeat classification on the second press.
                if (w_release) begin
                    w_state_nxt  = ST_IDLE;
                    w_double_nxt = 1'b1;
                    w_cnt_nxt    = 26'd0;
                end else begin
                    w_state_nxt = ST_PRESS2;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 26'd0;
            end
        endcase
        w_held_nxt = (w_state_nxt == ST_PRESS1) || (w_state_nxt == ST_LONG) ||
                     (w_state_nxt == ST_PRESS2);
    end

    // State, counter, input history and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 26'd0;
            r_key_d    <= 1'b1;
            r_armed    <= key_in;
            r_short    <= 1'b0;
            r_double   <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
            r_key_held <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_key_d    <= key_in;
            r_armed    <= r_armed | key_in;
            r_short    <= w_short_nxt;
            r_double   <= w_double_nxt;
            r_long     <= w_long_nxt;
            r_repeat   <= w_repeat_nxt;
            r_key_held <= w_held_nxt;
        end
    end

    assign short_pulse  = r_short;
    assign double_pulse = r_double;
    assign long_pulse   = r_long;
    assign repeat_pulse = r_repeat;
    assign key_held     = r_key_held;

endmodule

// File: tb/tb_key_event.sv
// -----------------------------------------------------------------------------
// tb_key_event
// Randomized plus directed stimulus for key_event with a timestamp-based
// reference model. Expected pulses are queued as (edge index, kind); a
// monitor compares every pulse the DUT presents against the queue head.
// -----------------------------------------------------------------------------
module tb_key_event;

    localparam int LT = 20;
    localparam int DT = 10;
    localparam int RT = 5;

    // Pulse kinds as one-hot {repeat, long, double, short}
    localparam logic [3:0] K_SHORT  = 4'b0001;
    localparam logic [3:0] K_DOUBLE = 4'b0010;
    localparam logic [3:0] K_LONG   = 4'b0100;
    localparam logic [3:0] K_REPEAT = 4'b1000;

    // Model phases
    localparam int P_IDLE  = 0;
    localparam int P_HELD1 = 1;
    localparam int P_LONG  = 2;
    localparam int P_WAIT  = 3;
    localparam int P_HELD2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_in = 1'b1;
    logic short_pulse, double_pulse, long_pulse, repeat_pulse, key_held;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  edge_n   = 0;

    int   ph      = P_IDLE;
    int   t0      = 0;
    logic m_prev  = 1'b1;
    logic m_armed = 1'b1;

    key_event #(
        .LONG_TIME  (LT),
        .DOUBLE_TIME(DT),
        .REPEAT_TIME(RT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .short_pulse (short_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .key_held    (key_held)
    );

    always #5 clk = ~clk;

    // Reference: timestamps of press/release/long entry, not a cycle counter.
    task automatic model_edge(input logic lvl, input logic rst);
        logic press;
        if (!rst) begin
            ph      = P_IDLE;
            m_prev  = 1'b1;
            m_armed = lvl;
        end else begin
            press = m_prev && !lvl && m_armed;
            case (ph)
                P_IDLE: if (press) begin ph = P_HELD1; t0 = edge_n; end
                P_HELD1: begin
                    if (lvl) begin
                        ph = P_WAIT; t0 = edge_n;
                    end else if (edge_n - t0 == LT) begin
                        ph = P_LONG; t0 = edge_n;
                        exp_q.push_back('{edge_n, K_LONG});
                    end
                end
                P_LONG: begin
                    if (lvl) ph = P_IDLE;
                    else if ((edge_n - t0) % RT == 0)
                        exp_q.push_back('{edge_n, K_REPEAT});
                end
                P_WAIT: begin
                    if (press) begin
                        ph = P_HELD2;
                    end else if (edge_n - t0 == DT) begin
                        ph = P_IDLE;
                        exp_q.push_back('{edge_n, K_SHORT});
                    end
                end
                P_HELD2: begin
                    if (lvl) begin
                        ph = P_IDLE;
                        exp_q.push_back('{edge_n, K_DOUBLE});
                    end
                end
                default: ph = P_IDLE;
            endcase
            m_prev = lvl;
            if (lvl) m_armed = 1'b1;
        end
    endtask

    task automatic step(input logic lvl, input logic rst);
        logic exp_held;
        @(negedge clk);
        key_in = lvl;
        rst_n  = rst;
        @(posedge clk);
        edge_n++;
        model_edge(lvl, rst);
        exp_held = (ph == P_HELD1) || (ph == P_LONG) || (ph == P_HELD2);
        #1;
        n_checks++;
        if (key_held !== exp_held) begin
            n_fail++;
            $display("FAIL key_held edge %0d: got %b want %b", edge_n, key_held, exp_held);
        end
    endtask

    task automatic run(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl, 1'b1);
    endtask

    // Monitor: every presented pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [3:0] obs;
        ev_t        e;
        obs = {repeat_pulse, long_pulse, double_pulse, short_pulse};
        while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_pulse: got none at edge %0d want kind %b", e.cyc, e.kind);
        end
        if (obs != 4'b0000) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse edge %0d: got %b want none", edge_n, obs);
            end else begin
                e = exp_q.pop_front();
                if (e.kind !== obs || e.cyc != edge_n) begin
                    n_fail++;
                    $display("FAIL pulse: got %b at edge %0d want %b at edge %0d",
                             obs, edge_n, e.kind, e.cyc);
                end
            end
        end
    end

    initial begin
        // Reset state
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++;
        if ({short_pulse, double_pulse, long_pulse, repeat_pulse, key_held} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {short_pulse, double_pulse, long_pulse, repeat_pulse, key_held});
        end
        run(1'b1, 3);

        // Single short press
        run(1'b0, 5);  run(1'b1, 20);
        // Double click
        run(1'b0, 5);  run(1'b1, 4);  run(1'b0, 3);  run(1'b1, 20);
        // Long press with repeats
        run(1'b0, 41); run(1'b1, 20);
        // Release exactly on the long terminal count
        run(1'b0, LT); run(1'b1, 20);
        // One cycle past it: long press
        run(1'b0, LT + 1); run(1'b1, 20);
        // Second press exactly on the double-click window expiry
        run(1'b0, 5);  run(1'b1, DT); run(1'b0, 3); run(1'b1, 20);
        // Reset during WAIT2 with the key held low through reset release
        run(1'b0, 5);  run(1'b1, 3);  step(1'b0, 1'b0); run(1'b0, 10);
        run(1'b1, 2);  run(1'b0, 5);  run(1'b1, 20);
        // Reset in the middle of a long press
        run(1'b0, 30); step(1'b0, 1'b0); run(1'b0, 8); run(1'b1, 20);

        // Randomized key activity with occasional resets
        for (int k = 0; k < 40; k++) begin
            run(1'b0, int'($urandom_range(45, 1)));
            if ($urandom_range(9, 0) == 0) step(1'($urandom_range(1, 0)), 1'b0);
            run(1'b1, int'($urandom_range(14, 1)));
        end

        run(1'b1, 30);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending pulses want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
